// File: rtl/mac_result_collector.sv
// Receive-side FIFO for the accumulator result stream: strobed words in, valid/ready out.
// Optional COLLECT_CNT_EN adds a 16-bit rx_count of all strobes (accepted + dropped).
module mac_result_collector #(
    parameter int DATA_W = 20,
    parameter int DEPTH  = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [DATA_W-1:0]        f_in,
    input  logic                     f_valid,
    output logic [DATA_W-1:0]        out_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     overflow,
    input  logic                     clear_ovf
`ifdef COLLECT_CNT_EN
    ,
    output logic [15:0]              rx_count
`endif
);
    localparam int PW = $clog2(DEPTH);
    localparam int LW = PW + 1;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PW-1:0]     wr_ptr, rd_ptr;
    logic              full, empty, push, pop, drop;

    assign empty     = (level == '0);
    assign full      = (level == LW'(DEPTH));
    assign out_valid = !empty;
    assign out_data  = out_valid ? mem[rd_ptr] : '0;
    assign pop       = out_valid && out_ready;
    // Upstream cannot stall: a full FIFO only accepts when a pop frees the head slot.
    assign push      = f_valid && (!full || pop);
    assign drop      = f_valid && full && !pop;

    always_ff @(posedge clk) begin
        if (!reset && push)
            mem[wr_ptr] <= f_in;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            level    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
            // Set wins over clear so a drop in the clearing cycle is never lost.
            if (drop)           overflow <= 1'b1;
            else if (clear_ovf) overflow <= 1'b0;
        end
    end

`ifdef COLLECT_CNT_EN
    always_ff @(posedge clk) begin
        if (reset)        rx_count <= '0;
        else if (f_valid) rx_count <= rx_count + 16'd1;
    end
`endif

endmodule

// File: tb/tb_mac_result_collector.sv
// Directed, table-driven bench for mac_result_collector (DATA_W=20, DEPTH=4).
// Covers the rx_count feature when compiled with COLLECT_CNT_EN.
module tb_mac_result_collector;
    logic        clk = 1'b0;
    logic        reset;
    logic [19:0] f_in;
    logic        f_valid;
    logic [19:0] out_data;
    logic        out_valid;
    logic        out_ready;
    logic [2:0]  level;
    logic        overflow;
    logic        clear_ovf;
`ifdef COLLECT_CNT_EN
    logic [15:0] rx_count;
`endif

    int total = 0;
    int bad   = 0;

    mac_result_collector #(.DATA_W(20), .DEPTH(4)) dut (
        .clk(clk), .reset(reset), .f_in(f_in), .f_valid(f_valid),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .level(level), .overflow(overflow), .clear_ovf(clear_ovf)
`ifdef COLLECT_CNT_EN
        , .rx_count(rx_count)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        fv;
        logic [19:0] d;
        logic        rdy;
        logic        clr;
        logic        ev;
        logic [19:0] ed;
        logic [2:0]  el;
        logic        eo;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(logic fv, logic [19:0] d, logic rdy, logic clr,
                                logic ev, logic [19:0] ed, logic [2:0] el, logic eo);
        vec_t v;
        v.fv = fv; v.d = d; v.rdy = rdy; v.clr = clr;
        v.ev = ev; v.ed = ed; v.el = el; v.eo = eo;
        return v;
    endfunction

    task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s[%0d]: got 0x%0h want 0x%0h", name, idx, act, exp);
        end
    endtask

    task automatic step(input logic fv, input logic [19:0] d, input logic rdy, input logic clr);
        f_valid = fv; f_in = d; out_ready = rdy; clear_ovf = clr;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all(input string name, input int idx, input logic ev, input logic [19:0] ed,
                           input logic [2:0] el, input logic eo);
        chk({name, ".valid"}, idx, 32'(out_valid), 32'(ev));
        chk({name, ".data"},  idx, 32'(out_data),  32'(ed));
        chk({name, ".level"}, idx, 32'(level),     32'(el));
        chk({name, ".ovf"},   idx, 32'(overflow),  32'(eo));
    endtask

    initial begin
        reset = 1'b1; f_valid = 1'b0; f_in = '0; out_ready = 1'b0; clear_ovf = 1'b0;
        // f_valid during reset must be ignored
        step(1'b1, 20'hABCDE, 1'b0, 1'b0);
        step(1'b1, 20'h11111, 1'b1, 1'b0);
        reset = 1'b0;
        chk_all("reset", 0, 1'b0, 20'h0, 3'd0, 1'b0);

        // single word, hold, pop
        tbl.push_back(mk(1, 20'h12345, 0, 0,  1, 20'h12345, 1, 0));
        tbl.push_back(mk(0, 20'h0,     0, 0,  1, 20'h12345, 1, 0));
        tbl.push_back(mk(0, 20'h0,     0, 0,  1, 20'h12345, 1, 0));
        tbl.push_back(mk(0, 20'h0,     1, 0,  0, 20'h0,     0, 0));
        // empty FIFO ignores out_ready
        tbl.push_back(mk(0, 20'h0,     1, 0,  0, 20'h0,     0, 0));
        // fill 1..4 then drop 5
        tbl.push_back(mk(1, 20'd1, 0, 0,  1, 20'd1, 1, 0));
        tbl.push_back(mk(1, 20'd2, 0, 0,  1, 20'd1, 2, 0));
        tbl.push_back(mk(1, 20'd3, 0, 0,  1, 20'd1, 3, 0));
        tbl.push_back(mk(1, 20'd4, 0, 0,  1, 20'd1, 4, 0));
        tbl.push_back(mk(1, 20'd5, 0, 0,  1, 20'd1, 4, 1));
        // drain yields 1..4 only
        tbl.push_back(mk(0, 20'd0, 1, 0,  1, 20'd2, 3, 1));
        tbl.push_back(mk(0, 20'd0, 1, 0,  1, 20'd3, 2, 1));
        tbl.push_back(mk(0, 20'd0, 1, 0,  1, 20'd4, 1, 1));
        tbl.push_back(mk(0, 20'd0, 1, 0,  0, 20'd0, 0, 1));
        tbl.push_back(mk(0, 20'd0, 0, 1,  0, 20'd0, 0, 0));
        // refill, then push+pop while full
        tbl.push_back(mk(1, 20'd1, 0, 0,  1, 20'd1, 1, 0));
        tbl.push_back(mk(1, 20'd2, 0, 0,  1, 20'd1, 2, 0));
        tbl.push_back(mk(1, 20'd3, 0, 0,  1, 20'd1, 3, 0));
        tbl.push_back(mk(1, 20'd4, 0, 0,  1, 20'd1, 4, 0));
        tbl.push_back(mk(1, 20'd9, 1, 0,  1, 20'd2, 4, 0));
        // clear_ovf together with a drop: set wins
        tbl.push_back(mk(1, 20'd7, 0, 1,  1, 20'd2, 4, 1));
        tbl.push_back(mk(0, 20'd0, 1, 0,  1, 20'd3, 3, 1));
        tbl.push_back(mk(0, 20'd0, 1, 0,  1, 20'd4, 2, 1));
        tbl.push_back(mk(0, 20'd0, 1, 0,  1, 20'd9, 1, 1));
        tbl.push_back(mk(0, 20'd0, 1, 1,  0, 20'd0, 0, 0));

        foreach (tbl[i]) begin
            step(tbl[i].fv, tbl[i].d, tbl[i].rdy, tbl[i].clr);
            chk_all("tbl", i, tbl[i].ev, tbl[i].ed, tbl[i].el, tbl[i].eo);
        end

        // streaming: each word visible one cycle after strobe, level stays 1
        for (int i = 0; i < 100; i++) begin
            step(1'b1, 20'(i), 1'b1, 1'b0);
            chk_all("stream", i, 1'b1, 20'(i), 3'd1, 1'b0);
        end
        step(1'b0, 20'h0, 1'b1, 1'b0);
        chk_all("stream_end", 0, 1'b0, 20'h0, 3'd0, 1'b0);

        // mid-operation reset with 3 stored words and an overflow pending
        for (int i = 0; i < 5; i++) step(1'b1, 20'(16'hA0 + i), 1'b0, 1'b0);
        step(1'b0, 20'h0, 1'b1, 1'b0);
        chk_all("pre_rst", 0, 1'b1, 20'hA1, 3'd3, 1'b1);
        out_ready = 1'b0;
        reset = 1'b1;
        step(1'b1, 20'hBAD, 1'b0, 1'b0);
        reset = 1'b0;
        chk_all("mid_rst", 0, 1'b0, 20'h0, 3'd0, 1'b0);
        step(1'b1, 20'h55, 1'b0, 1'b0);
        chk_all("post_rst", 0, 1'b1, 20'h55, 3'd1, 1'b0);
        step(1'b0, 20'h0, 1'b1, 1'b0);
        chk_all("post_rst", 1, 1'b0, 20'h0, 3'd0, 1'b0);

`ifdef COLLECT_CNT_EN
        reset = 1'b1;
        step(1'b0, 20'h0, 1'b0, 1'b0);
        reset = 1'b0;
        chk("rx_rst", 0, 32'(rx_count), 32'd0);
        // 8 strobes with no consumer: 4 accepted, 4 dropped
        for (int i = 0; i < 8; i++) step(1'b1, 20'(i), 1'b0, 1'b0);
        chk("rx_8", 0, 32'(rx_count), 32'd8);
        chk("rx_ovf", 0, 32'(overflow), 32'd1);
        // remaining strobes while popping every cycle: no further drops
        for (int i = 0; i < 65530; i++) step(1'b1, 20'(i), 1'b1, 1'b0);
        chk("rx_wrap", 0, 32'(rx_count), 32'd2);
        chk("rx_lvl", 0, 32'(level), 32'd4);
        step(1'b0, 20'h0, 1'b0, 1'b1);
        chk("rx_clr", 0, 32'(rx_count), 32'd2);
        chk("rx_clr_ovf", 0, 32'(overflow), 32'd0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
